// File: rtl/gf180mcu_rst_seq_pkg.sv
// Shared types and parameter limits for the staged reset sequencer.
// Holds the FSM state encoding and the counter sizing helper.
package gf180mcu_rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLD    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   localparam int MIN_DOMAINS = 1;
   localparam int MAX_DOMAINS = 16;
   localparam int MIN_HOLD    = 1;
   localparam int MIN_GAP     = 1;
   localparam int MIN_SYNC    = 2;

   // Wide enough to reach the larger of the two terminal counts without wrapping.
   function automatic int cnt_width(input int hold, input int gap);
      return $clog2((hold > gap) ? hold : gap) + 1;
   endfunction

endpackage

// File: rtl/gf180mcu_rst_seq_sync.sv
// Multi-flop synchronizer for the asynchronous active-low reset request.
// A synchronous clear forces the output low, which reads as a pending request.
module gf180mcu_rst_seq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rn,
   input  logic req_n,
   output logic req_s
);

   logic [SYNC_STAGES-1:0] stages;

   always_ff @(posedge clk) begin
      if (!rn) begin
         stages <= '0;
      end else begin
         stages <= {stages[SYNC_STAGES-2:0], req_n};
      end
   end

   assign req_s = stages[SYNC_STAGES-1];

endmodule

// File: rtl/gf180mcu_rst_seq.sv
// Staged reset sequencer: holds all downstream resets after a request clears,
// then releases them one domain at a time in ascending order.
module gf180mcu_rst_seq
   import gf180mcu_rst_seq_pkg::*;
#(
   parameter int NUM_DOMAINS = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int RELEASE_GAP = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   CLK,
   input  logic                   RN,
   input  logic                   REQ_N,
   output logic [NUM_DOMAINS-1:0] RSTN_OUT,
   output logic                   BUSY,
   output logic                   DONE
);

   if (NUM_DOMAINS < MIN_DOMAINS || NUM_DOMAINS > MAX_DOMAINS) begin : g_bad_domains
      $error("gf180mcu_rst_seq: NUM_DOMAINS must be in 1..16");
   end
   if (HOLD_CYCLES < MIN_HOLD) begin : g_bad_hold
      $error("gf180mcu_rst_seq: HOLD_CYCLES must be >= 1");
   end
   if (RELEASE_GAP < MIN_GAP) begin : g_bad_gap
      $error("gf180mcu_rst_seq: RELEASE_GAP must be >= 1");
   end
   if (SYNC_STAGES < MIN_SYNC) begin : g_bad_sync
      $error("gf180mcu_rst_seq: SYNC_STAGES must be >= 2");
   end

   localparam int CNT_W = cnt_width(HOLD_CYCLES, RELEASE_GAP);
   localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]       GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
   localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
   localparam logic [NUM_DOMAINS-1:0] DOM0      = NUM_DOMAINS'(1);

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [IDX_W-1:0]       idx;
   logic [NUM_DOMAINS-1:0] rstn;
   logic                   busy;
   logic                   done;
   logic                   req_s;

   gf180mcu_rst_seq_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (CLK),
      .rn    (RN),
      .req_n (REQ_N),
      .req_s (req_s)
   );

   always_ff @(posedge CLK) begin
      if (!RN) begin
         state <= ST_ASSERT;
         rstn  <= '0;
         busy  <= 1'b1;
         done  <= 1'b0;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               rstn <= '1;
               busy <= 1'b0;
               cnt  <= '0;
               idx  <= '0;
               if (!req_s) begin
                  state <= ST_ASSERT;
                  rstn  <= '0;
                  busy  <= 1'b1;
               end
            end
            ST_ASSERT: begin
               rstn <= '0;
               busy <= 1'b1;
               cnt  <= '0;
               idx  <= '0;
               if (req_s) begin
                  state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!req_s) begin
                  state <= ST_ASSERT;
                  rstn  <= '0;
                  cnt   <= '0;
                  idx   <= '0;
               end else if (cnt == HOLD_LAST) begin
                  rstn <= rstn | DOM0;
                  cnt  <= '0;
                  if (NUM_DOMAINS == 1) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     idx   <= '0;
                  end else begin
                     state <= ST_RELEASE;
                     idx   <= IDX_W'(1);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               if (!req_s) begin
                  state <= ST_ASSERT;
                  rstn  <= '0;
                  cnt   <= '0;
                  idx   <= '0;
               end else if (cnt == GAP_LAST) begin
                  // idx names the next domain to release; the last one ends the sequence.
                  rstn <= rstn | (DOM0 << idx);
                  cnt  <= '0;
                  if (idx == LAST_IDX) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     idx   <= '0;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= ST_ASSERT;
               rstn  <= '0;
               busy  <= 1'b1;
               cnt   <= '0;
               idx   <= '0;
            end
         endcase
      end
   end

   assign RSTN_OUT = rstn;
   assign BUSY     = busy;
   assign DONE     = done;

endmodule

// File: tb/tb_gf180mcu_rst_seq.sv
// Directed bench for the staged reset sequencer; expected per-cycle outputs are
// derived from the release-edge formula and drained by a negedge checker.
module tb_gf180mcu_rst_seq;

   localparam int N0 = 4;
   localparam int H0 = 16;
   localparam int G0 = 2;
   localparam int NEVER = 1000000;

   typedef struct {
      int         unit;
      int         cyc;
      logic [3:0] rstn;
      logic       busy;
      logic       done;
   } exp_t;

   logic          CLK;
   logic          RN;
   logic          REQ_N;
   logic [N0-1:0] RSTN_OUT;
   logic          BUSY;
   logic          DONE;

   logic          rn1;
   logic          req1_n;
   logic [0:0]    rstn1;
   logic          busy1;
   logic          done1;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic stim_done = 1'b0;
   exp_t sb[$];

   gf180mcu_rst_seq #(
      .NUM_DOMAINS (N0),
      .HOLD_CYCLES (H0),
      .RELEASE_GAP (G0),
      .SYNC_STAGES (2)
   ) dut (
      .CLK      (CLK),
      .RN       (RN),
      .REQ_N    (REQ_N),
      .RSTN_OUT (RSTN_OUT),
      .BUSY     (BUSY),
      .DONE     (DONE)
   );

   gf180mcu_rst_seq #(
      .NUM_DOMAINS (1),
      .HOLD_CYCLES (1),
      .RELEASE_GAP (1),
      .SYNC_STAGES (2)
   ) dut1 (
      .CLK      (CLK),
      .RN       (rn1),
      .REQ_N    (req1_n),
      .RSTN_OUT (rstn1),
      .BUSY     (busy1),
      .DONE     (done1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Outputs after edge c: idle before the assert edge a, otherwise domain i is
   // high from edge k+h+i*g, and the last release ends BUSY and pulses DONE.
   function automatic exp_t mk(input int unit, input int c, input int a, input int k,
                               input int n, input int h, input int g);
      exp_t e;
      e.unit = unit;
      e.cyc  = c;
      e.rstn = '0;
      e.busy = 1'b0;
      e.done = 1'b0;
      if (c < a) begin
         for (int i = 0; i < n; i++) e.rstn[i] = 1'b1;
      end else begin
         for (int i = 0; i < n; i++) if (c >= k + h + i * g) e.rstn[i] = 1'b1;
         e.busy = (c < k + h + (n - 1) * g);
         e.done = (c == k + h + (n - 1) * g);
      end
      return e;
   endfunction

   function automatic void sb_insert(input exp_t e);
      int p;
      p = sb.size();
      while (p > 0 && sb[p-1].cyc > e.cyc) p--;
      sb.insert(p, e);
   endfunction

   task automatic push_win(input int unit, input int from, input int to, input int a,
                           input int k, input int n, input int h, input int g);
      for (int c = from; c <= to; c++) sb_insert(mk(unit, c, a, k, n, h, g));
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         n_checks++;
         assert (e.cyc == cyc) else begin
            n_fail++;
            $error("FAIL sb_timing observed=%0d expected=%0d", cyc, e.cyc);
         end
         if (e.unit == 0) begin
            n_checks++;
            assert (RSTN_OUT === e.rstn) else begin
               n_fail++;
               $error("FAIL rstn_out cyc=%0d observed=%b expected=%b", cyc, RSTN_OUT, e.rstn);
            end
            n_checks++;
            assert (BUSY === e.busy) else begin
               n_fail++;
               $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, BUSY, e.busy);
            end
            n_checks++;
            assert (DONE === e.done) else begin
               n_fail++;
               $error("FAIL done cyc=%0d observed=%b expected=%b", cyc, DONE, e.done);
            end
         end else begin
            n_checks++;
            assert (rstn1 === e.rstn[0:0]) else begin
               n_fail++;
               $error("FAIL n1_rstn_out cyc=%0d observed=%b expected=%b", cyc, rstn1, e.rstn[0]);
            end
            n_checks++;
            assert (busy1 === e.busy) else begin
               n_fail++;
               $error("FAIL n1_busy cyc=%0d observed=%b expected=%b", cyc, busy1, e.busy);
            end
            n_checks++;
            assert (done1 === e.done) else begin
               n_fail++;
               $error("FAIL n1_done cyc=%0d observed=%b expected=%b", cyc, done1, e.done);
            end
         end
      end
      if (stim_done) begin
         n_checks++;
         assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
         end
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
         $finish;
      end
   end

   initial begin
      int c0;
      RN     = 1'b0;
      REQ_N  = 1'b1;
      rn1    = 1'b0;
      req1_n = 1'b1;

      // Reset held three edges, then startup release sequence on both instances.
      push_win(0, 1, 3, 1, NEVER, N0, H0, G0);
      push_win(1, 1, 3, 1, NEVER, 1, 1, 1);
      step(3);
      c0 = cyc;
      push_win(0, c0 + 1, c0 + 30, c0 + 1, c0 + 3, N0, H0, G0);
      push_win(1, c0 + 1, c0 + 6, c0 + 1, c0 + 3, 1, 1, 1);
      RN  = 1'b1;
      rn1 = 1'b1;
      step(30);

      // Five-cycle request on the main instance, one-cycle request on the small one.
      c0 = cyc;
      push_win(0, c0 + 1, c0 + 36, c0 + 3, c0 + 8, N0, H0, G0);
      push_win(1, c0 + 1, c0 + 7, c0 + 3, c0 + 4, 1, 1, 1);
      REQ_N  = 1'b0;
      req1_n = 1'b0;
      step(1);
      req1_n = 1'b1;
      step(4);
      REQ_N = 1'b1;
      step(31);

      // One-cycle request, then abort after domain 1 has been released.
      c0 = cyc;
      push_win(0, c0 + 1, c0 + 24, c0 + 3, c0 + 4, N0, H0, G0);
      push_win(0, c0 + 25, c0 + 54, c0 + 25, c0 + 26, N0, H0, G0);
      REQ_N = 1'b0;
      step(1);
      REQ_N = 1'b1;
      step(21);
      REQ_N = 1'b0;
      step(1);
      REQ_N = 1'b1;
      step(31);

      // Sub-cycle glitch between edges must not be seen.
      c0 = cyc;
      push_win(0, c0 + 1, c0 + 4, c0 + 5, NEVER, N0, H0, G0);
      REQ_N = 1'b0;
      #3;
      REQ_N = 1'b1;
      step(4);

      // RN during RELEASE wins over the pending release and restarts the sequence.
      c0 = cyc;
      push_win(0, c0 + 1, c0 + 21, c0 + 3, c0 + 4, N0, H0, G0);
      push_win(0, c0 + 22, c0 + 54, c0 + 22, c0 + 26, N0, H0, G0);
      REQ_N = 1'b0;
      step(1);
      REQ_N = 1'b1;
      step(20);
      RN = 1'b0;
      step(2);
      RN = 1'b1;
      step(31);

      stim_done = 1'b1;
      repeat (10) @(posedge CLK);
      $display("FAIL checker_stall observed=no_summary expected=summary");
      $fatal(1, "checker did not terminate");
   end

endmodule
